// File: rtl/prores_enc_pkg.sv
// Shared types and helpers for the slice encode scheduler.
// Covers the scheduler state encoding, the component indices and the mb_count legality test.
package prores_enc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    GAP,
    DONE
  } sched_state_t;

  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;

  // Legal slice sizes are the powers of two up to max_mb.
  function automatic logic is_legal_mb(input logic [3:0] mb, input int unsigned max_mb);
    return (mb != 4'd0) && ((mb & (mb - 4'd1)) == 4'd0) && ({28'd0, mb} <= max_mb);
  endfunction

endpackage

// File: rtl/pass_cycle_counter.sv
// Loadable down-counter that times one datapath pass.
// The zero flag marks the last cycle of the pass.
module pass_cycle_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                    count <= '0;
    else if (load)                count <= load_val;
    else if (dec && count != '0)  count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/slice_component_scheduler.sv
// Steps the component datapath through the Y, Cb and Cr passes of a slice.
// Pass completion is count-based because the datapath has no done signal.
module slice_component_scheduler
  import prores_enc_pkg::*;
#(
  parameter int unsigned RUN_BASE      = 16,
  parameter int unsigned RUN_PER_BLOCK = 64,
  parameter int unsigned MAX_MB        = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  mb_count,
  input  logic [31:0] y_offset,
  input  logic [31:0] cb_offset,
  input  logic [31:0] cr_offset,
  output logic        component_reset_n,
  output logic        is_y,
  output logic [31:0] block_num,
  output logic [31:0] offset,
  output logic [1:0]  comp_idx,
  output logic        busy,
  output logic        done,
  output logic        err
);

  sched_state_t state, state_nxt;

  logic [3:0]  mb_q;
  logic [31:0] cb_off_q, cr_off_q;
  logic [31:0] run_len_m1;
  logic        start_ok, start_bad;
  logic        cnt_load, cnt_dec, cnt_zero;

  assign start_ok  = (state == IDLE) && start &&  is_legal_mb(mb_count, MAX_MB);
  assign start_bad = (state == IDLE) && start && !is_legal_mb(mb_count, MAX_MB);

  // block_num already holds the upcoming pass's count in LOAD and GAP.
  assign run_len_m1 = RUN_BASE + block_num * RUN_PER_BLOCK - 32'd1;

  pass_cycle_counter #(.W(32)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (run_len_m1),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: if (start_ok) state_nxt = LOAD;
      LOAD: begin
        cnt_load  = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_nxt = (comp_idx < COMP_CR) ? GAP : DONE;
      end
      GAP: begin
        cnt_load  = 1'b1;
        state_nxt = RUN;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Cancel wins over any pass-end transition.
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
    end
  end

  // Outputs are registered off the next state so they line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      component_reset_n <= 1'b0;
      is_y              <= 1'b0;
      block_num         <= '0;
      offset            <= '0;
      comp_idx          <= COMP_Y;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      mb_q              <= '0;
      cb_off_q          <= '0;
      cr_off_q          <= '0;
    end else begin
      component_reset_n <= (state_nxt == RUN);
      busy              <= (state_nxt == LOAD) || (state_nxt == RUN) || (state_nxt == GAP);
      done              <= (state_nxt == DONE);
      err               <= start_bad;
      if (start_ok) begin
        mb_q      <= mb_count;
        cb_off_q  <= cb_offset;
        cr_off_q  <= cr_offset;
        is_y      <= 1'b1;
        comp_idx  <= COMP_Y;
        block_num <= {28'd0, mb_count} << 2;
        offset    <= y_offset;
      end else if (state == RUN && state_nxt == GAP) begin
        is_y      <= 1'b0;
        comp_idx  <= comp_idx + 2'd1;
        block_num <= {28'd0, mb_q} << 1;
        offset    <= (comp_idx == COMP_Y) ? cb_off_q : cr_off_q;
      end
    end
  end

endmodule

// File: tb/tb_slice_component_scheduler.sv
// Scoreboard bench: stimulus queues expected pass/done/err events, a negedge monitor
// rebuilds events from the DUT outputs and compares them in order.
module tb_slice_component_scheduler;

  localparam int K_PASS = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int kind;
    int cyc;
    int comp;
    int isy;
    int blk;
    int off;
    int len;
    int stable;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  mb_count = '0;
  logic [31:0] y_offset = '0, cb_offset = '0, cr_offset = '0;
  logic        component_reset_n, is_y, busy, done, err;
  logic [31:0] block_num, offset;
  logic [1:0]  comp_idx;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  ev_t exp_q[$];

  slice_component_scheduler dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .abort             (abort),
    .mb_count          (mb_count),
    .y_offset          (y_offset),
    .cb_offset         (cb_offset),
    .cr_offset         (cr_offset),
    .component_reset_n (component_reset_n),
    .is_y              (is_y),
    .block_num         (block_num),
    .offset            (offset),
    .comp_idx          (comp_idx),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_pass(input int c, input int comp, input int blk, input int off, input int len);
    ev_t e;
    e = '{kind: K_PASS, cyc: c, comp: comp, isy: (comp == 0) ? 1 : 0, blk: blk, off: off, len: len, stable: 1};
    exp_q.push_back(e);
  endtask

  task automatic push_evt(input int kind, input int c);
    ev_t e;
    e = '{kind: kind, cyc: c, comp: 0, isy: 0, blk: 0, off: 0, len: 0, stable: 0};
    exp_q.push_back(e);
  endtask

  // Full slice expectations from the pass-length formula and the LOAD/GAP/DONE single cycles.
  task automatic push_slice(input int c0, input int mb, input int yo, input int co, input int ro);
    int ry, rc, ys, cs, rs;
    ry = 16 + 4 * mb * 64;
    rc = 16 + 2 * mb * 64;
    ys = c0 + 2;
    cs = ys + ry + 1;
    rs = cs + rc + 1;
    push_pass(ys, 0, 4 * mb, yo, ry);
    push_pass(cs, 1, 2 * mb, co, rc);
    push_pass(rs, 2, 2 * mb, ro, rc);
    push_evt(K_DONE, rs + rc);
  endtask

  task automatic emit(input ev_t a);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, required no event", a.kind, a.cyc);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", a.kind, e.kind);
      chk("ev_cycle", a.cyc, e.cyc);
      if (e.kind == K_PASS && a.kind == K_PASS) begin
        chk("pass_comp_idx", a.comp, e.comp);
        chk("pass_is_y", a.isy, e.isy);
        chk("pass_block_num", a.blk, e.blk);
        chk("pass_offset", a.off, e.off);
        chk("pass_run_len", a.len, e.len);
        chk("pass_stable", a.stable, e.stable);
      end
    end
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic start_slice(input int mb, input int yo, input int co, input int ro, output int c0);
    c0        = cyc;
    mb_count  = 4'(mb);
    y_offset  = 32'(yo);
    cb_offset = 32'(co);
    cr_offset = 32'(ro);
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_component_reset_n"}, component_reset_n, 0);
    chk({tag, "_is_y"}, is_y, 0);
    chk({tag, "_block_num"}, block_num, 0);
    chk({tag, "_offset"}, offset, 0);
    chk({tag, "_comp_idx"}, comp_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Monitor: a RUN is the span where component_reset_n is high.
  initial begin
    ev_t r;
    ev_t p;
    bit in_run;
    in_run = 0;
    r = '{kind: K_PASS, cyc: 0, comp: 0, isy: 0, blk: 0, off: 0, len: 0, stable: 0};
    forever begin
      @(negedge clock);
      if (reset) begin
        in_run = 0;
      end else begin
        if (component_reset_n) begin
          if (!in_run) begin
            in_run = 1;
            r = '{kind: K_PASS, cyc: cyc, comp: int'(comp_idx), isy: int'(is_y),
                  blk: int'(block_num), off: int'(offset), len: 0, stable: 1};
          end else if (r.comp != int'(comp_idx) || r.isy != int'(is_y) ||
                       r.blk != int'(block_num) || r.off != int'(offset)) begin
            r.stable = 0;
          end
          r.len++;
        end else if (in_run) begin
          in_run = 0;
          emit(r);
        end
        if (done) begin
          p = '{kind: K_DONE, cyc: cyc, comp: 0, isy: 0, blk: 0, off: 0, len: 0, stable: 0};
          emit(p);
        end
        if (err) begin
          p = '{kind: K_ERR, cyc: cyc, comp: 0, isy: 0, blk: 0, off: 0, len: 0, stable: 0};
          emit(p);
        end
      end
    end
  end

  initial begin
    int c0;
    repeat (3) @(posedge clock);
    #1;
    chk_reset_vals("in_reset");
    reset = 1'b0;
    to_cyc(cyc + 2);
    chk_reset_vals("after_reset");

    // mb=1: Y 2..273, Cb 275..418, Cr 420..563, done 564
    start_slice(1, 'h100, 'h200, 'h300, c0);
    push_pass(c0 + 2,   0, 4, 'h100, 272);
    push_pass(c0 + 275, 1, 2, 'h200, 144);
    push_pass(c0 + 420, 2, 2, 'h300, 144);
    push_evt(K_DONE, c0 + 564);
    to_cyc(c0 + 1);
    chk("load_busy", busy, 1);
    chk("load_component_reset_n", component_reset_n, 0);
    to_cyc(c0 + 570);

    // mb=8: Y 2064 cycles, chroma 1040 each, single GAP cycles at 2066 and 3107
    start_slice(8, 'h000, 'h800, 'hC00, c0);
    push_pass(c0 + 2,    0, 32, 'h000, 2064);
    push_pass(c0 + 2067, 1, 16, 'h800, 1040);
    push_pass(c0 + 3108, 2, 16, 'hC00, 1040);
    push_evt(K_DONE, c0 + 4148);
    to_cyc(c0 + 2066);
    chk("gap1_component_reset_n", component_reset_n, 0);
    chk("gap1_busy", busy, 1);
    to_cyc(c0 + 4160);

    // Illegal sizes
    start_slice(3, 'h10, 'h20, 'h30, c0);
    push_evt(K_ERR, c0 + 1);
    to_cyc(c0 + 1);
    chk("err3_busy", busy, 0);
    chk("err3_component_reset_n", component_reset_n, 0);
    to_cyc(c0 + 2);
    chk("err3_pulse_width", err, 0);
    start_slice(0, 0, 0, 0, c0);
    push_evt(K_ERR, c0 + 1);
    to_cyc(c0 + 3);
    start_slice(9, 0, 0, 0, c0);
    push_evt(K_ERR, c0 + 1);
    to_cyc(c0 + 5);

    // Second start mid-Cb and input changes are ignored; start during DONE is ignored
    start_slice(1, 'h40, 'h50, 'h60, c0);
    push_slice(c0, 1, 'h40, 'h50, 'h60);
    to_cyc(c0 + 300);
    mb_count = 4'd8; y_offset = 'h999; cb_offset = 'h888; cr_offset = 'h777;
    start = 1'b1;
    to_cyc(c0 + 301);
    start = 1'b0;
    to_cyc(c0 + 564);
    start = 1'b1;
    to_cyc(c0 + 565);
    start = 1'b0;
    chk("start_in_done_busy", busy, 0);
    to_cyc(c0 + 580);

    // Abort mid-Cb at cycle 300, restart at 305
    start_slice(1, 'h1, 'h2, 'h3, c0);
    push_pass(c0 + 2,   0, 4, 'h1, 272);
    push_pass(c0 + 275, 1, 2, 'h2, 26);
    to_cyc(c0 + 300);
    abort = 1'b1;
    to_cyc(c0 + 301);
    abort = 1'b0;
    chk("abort_component_reset_n", component_reset_n, 0);
    chk("abort_busy", busy, 0);
    to_cyc(c0 + 305);
    start_slice(1, 'h11, 'h22, 'h33, c0);
    push_slice(c0, 1, 'h11, 'h22, 'h33);
    to_cyc(c0 + 580);

    // Async reset mid-Y, then mb=2 (Y run 528, chroma 272)
    start_slice(4, 'h5, 'h6, 'h7, c0);
    to_cyc(c0 + 100);
    chk("pre_reset_component_reset_n", component_reset_n, 1);
    #2 reset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    to_cyc(c0 + 103);
    reset = 1'b0;
    to_cyc(c0 + 105);
    start_slice(2, 'h1000, 'h2000, 'h3000, c0);
    push_pass(c0 + 2, 0, 8, 'h1000, 528);
    push_pass(c0 + 531, 1, 4, 'h2000, 272);
    push_pass(c0 + 804, 2, 4, 'h3000, 272);
    push_evt(K_DONE, c0 + 1076);
    to_cyc(c0 + 1090);

    chk("leftover_expected_events", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/slice_component_scheduler.md
Name: slice_component_scheduler

Overview:
- Sequences the per-component encode datapath (`component`) through the Y, Cb and Cr passes of one slice.
- For each pass it drives `is_y`, `block_num`, input offset and the datapath's active-low reset, then holds the pass for a computed cycle budget.
- The datapath has no done signal, so pass completion is purely count-based.
- Sits between the slice-level controller (start/done handshake) and the `component` instance.

Parameters:
- RUN_BASE, 16: fixed pipeline/flush cycles per pass.
- RUN_PER_BLOCK, 64: cycles per 8x8 block per pass.
- MAX_MB, 8: largest legal macroblocks-per-slice.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to encode a slice; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current slice.
- mb_count  in  4  macroblocks in slice; legal values 1, 2, 4, 8.
- y_offset  in  32  INPUT_DATA_MEM word offset of the Y samples.
- cb_offset  in  32  word offset of the Cb samples.
- cr_offset  in  32  word offset of the Cr samples.
- component_reset_n  out  1  active-low reset to the datapath; 0 except during RUN.
- is_y  out  1  1 during the Y pass.
- block_num  out  32  blocks in the current pass.
- offset  out  32  offset of the current pass.
- comp_idx  out  2  current pass: 0=Y, 1=Cb, 2=Cr.
- busy  out  1  1 from LOAD through the last RUN cycle.
- done  out  1  one-cycle pulse on slice completion.
- err  out  1  one-cycle pulse when start carries an illegal mb_count.

Behaviour:
- Reset values: component_reset_n=0, is_y=0, block_num=0, offset=0, comp_idx=0, busy=0, done=0, err=0. State is IDLE and the cycle counter is 0.
- Block counts (4:2:2): Y = 4*mb_count; Cb = Cr = 2*mb_count.
- Pass length: run_len = RUN_BASE + blocks*RUN_PER_BLOCK, computed in 32-bit unsigned.
- States and transitions:
  - IDLE:
    - start=1 with legal mb_count: capture mb_count and the three offsets, go to LOAD.
    - start=1 with illegal mb_count (0, 3, 5-7, >MAX_MB): err=1 next cycle, stay IDLE, no done.
  - LOAD (1 cycle):
    - Outputs: component_reset_n=0, is_y=1, comp_idx=0, block_num=4*mb, offset=captured y_offset, busy=1.
    - Counter loads run_len-1. Next state RUN.
  - RUN:
    - component_reset_n=1; counter decrements each cycle.
    - At counter==0: if comp_idx<2, go to GAP; otherwise go to DONE.
  - GAP (1 cycle):
    - component_reset_n=0; comp_idx increments; is_y=0.
    - block_num=2*mb; offset switches to the Cb or Cr offset.
    - Counter reloads run_len-1. Next state RUN.
  - DONE (1 cycle):
    - done=1, busy=0, component_reset_n=0. Next state IDLE.
- Output timing:
  - is_y, block_num, offset and comp_idx are stable for the whole of each RUN.
  - They change only in LOAD or GAP, while the datapath is held in reset.
- Interaction and boundary cases:
  - start while not IDLE is ignored.
  - start and done in the same cycle: start is ignored, because done occurs in the DONE state.
  - abort in any non-IDLE state: next cycle goes to IDLE with component_reset_n=0, busy=0, and no done pulse.
  - abort has priority over the RUN-end transition; abort in IDLE has no effect.
  - Captured inputs are frozen for the slice; changes to mb_count or offsets mid-slice have no effect.
  - Asynchronous reset mid-slice returns to the reset values immediately; no done is produced.
- Latency: with start sampled at cycle 0, done is high at cycle 1 + runY + 1 + runC + 1 + runC + 1, where runY and runC are the Y and chroma pass lengths.

Decomposition:
- Shared package `prores_enc_pkg`:
  - state enum `sched_state_t` (IDLE, LOAD, RUN, GAP, DONE);
  - COMP_Y/COMP_CB/COMP_CR constants;
  - `function is_legal_mb(mb)`.
- One sub-module, `pass_cycle_counter`: a loadable 32-bit down-counter with a `zero` flag, shared by all passes.

Test Plan:
- mb_count=1, defaults, start at cycle 0:
  - Y RUN covers cycles 2-273 (272 cycles), with block_num=4 and is_y=1.
  - Cb RUN covers 275-418, Cr RUN covers 420-563, both with block_num=2.
  - done pulses at cycle 564.
- mb_count=8, y/cb/cr offsets 0x000/0x800/0xC00:
  - block_num sequence is 32, 16, 16 and offsets are 0x000, 0x800, 0xC00.
  - Y RUN is 2064 cycles; each chroma RUN is 1040 cycles.
  - component_reset_n=0 in exactly 2 GAP cycles.
- mb_count=3 start: err pulses 1 cycle later; busy stays 0 and component_reset_n stays 0.
- A second start mid-Cb pass is ignored; mb_count changed to 8 mid-slice still yields Cr block_num=2; done occurs exactly once.
- abort asserted at cycle 300 (Cb pass, mb=1): at cycle 301 component_reset_n=0 and busy=0, and no done follows. A new start at cycle 305 produces a full slice.
- reset asserted mid-Y pass: all outputs return to reset values asynchronously. After release, start with mb=2 gives Y RUN = 16+8*64 = 528 cycles.
